// File: rtl/if_fetch_ctrl_pkg.sv
// Shared cpu package: fetch state encoding, reset PC and instruction bus constants.
package if_fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      FS_IDLE = 2'd0,
      FS_REQ  = 2'd1,
      FS_WAIT = 2'd2,
      FS_HOLD = 2'd3
   } fs_state_e;

   localparam logic [31:0] CPU_RESET_PC    = 32'h1c00_0000;
   localparam logic [1:0]  INST_SIZE_WORD  = 2'b10;
   localparam logic [3:0]  INST_WSTRB_NONE = 4'b0000;

   // A fetch address is usable only when word aligned.
   function automatic logic pc_misaligned(input logic [31:0] pc);
      return pc[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/if_fetch_ctrl.sv
// Instruction fetch controller: issues one instruction read at a time, buffers the
// returned word for decode and handles redirects that race with an outstanding read.
module if_fetch_ctrl
   import if_fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = CPU_RESET_PC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        ds_allowin,
   output logic        inst_sram_req,
   output logic        inst_sram_wr,
   output logic [1:0]  inst_sram_size,
   output logic [3:0]  inst_sram_wstrb,
   output logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_wdata,
   input  logic        inst_sram_addr_ok,
   input  logic        inst_sram_data_ok,
   input  logic [31:0] inst_sram_rdata,
   output logic        fs_to_ds_valid,
   output logic [31:0] fs_pc,
   output logic [31:0] fs_inst,
   output logic        fs_adef
);

   fs_state_e   state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic        adef_q, adef_d;
   logic        cancel_q, cancel_d;
   logic        pend_valid_q, pend_valid_d;
   logic [31:0] pend_pc_q, pend_pc_d;
   logic        launch;
   logic [31:0] launch_pc;

   // Next-state logic; "launch" starts a fresh fetch at launch_pc, which diverts
   // straight to HOLD with an address fault when the address is misaligned.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      inst_d       = inst_q;
      adef_d       = adef_q;
      cancel_d     = cancel_q;
      pend_valid_d = pend_valid_q;
      pend_pc_d    = pend_pc_q;
      launch       = 1'b0;
      launch_pc    = pc_q;
      case (state_q)
         FS_IDLE: begin
            launch    = 1'b1;
            launch_pc = RESET_PC;
         end
         FS_REQ: begin
            if (inst_sram_addr_ok) begin
               state_d = FS_WAIT;
               if (br_taken || pend_valid_q) begin
                  cancel_d = 1'b1;
               end
            end
            if (br_taken) begin
               pend_valid_d = 1'b1;
               pend_pc_d    = br_target;
            end
         end
         FS_WAIT: begin
            if (inst_sram_data_ok) begin
               if (br_taken) begin
                  launch    = 1'b1;
                  launch_pc = br_target;
               end else if (cancel_q) begin
                  launch    = 1'b1;
                  launch_pc = pend_pc_q;
               end else begin
                  state_d = FS_HOLD;
                  inst_d  = inst_sram_rdata;
                  adef_d  = 1'b0;
               end
            end else if (br_taken) begin
               cancel_d     = 1'b1;
               pend_valid_d = 1'b1;
               pend_pc_d    = br_target;
            end
         end
         FS_HOLD: begin
            if (br_taken) begin
               launch    = 1'b1;
               launch_pc = br_target;
            end else if (ds_allowin) begin
               launch    = 1'b1;
               launch_pc = pc_q + 32'd4;
            end
         end
         default: state_d = FS_IDLE;
      endcase
      if (launch) begin
         pc_d         = launch_pc;
         cancel_d     = 1'b0;
         pend_valid_d = 1'b0;
         if (pc_misaligned(launch_pc)) begin
            state_d = FS_HOLD;
            adef_d  = 1'b1;
            inst_d  = 32'd0;
         end else begin
            state_d = FS_REQ;
            adef_d  = 1'b0;
         end
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= FS_IDLE;
         pc_q         <= RESET_PC;
         inst_q       <= 32'd0;
         adef_q       <= 1'b0;
         cancel_q     <= 1'b0;
         pend_valid_q <= 1'b0;
         pend_pc_q    <= 32'd0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inst_q       <= inst_d;
         adef_q       <= adef_d;
         cancel_q     <= cancel_d;
         pend_valid_q <= pend_valid_d;
         pend_pc_q    <= pend_pc_d;
      end
   end

   assign inst_sram_req   = (state_q == FS_REQ);
   assign inst_sram_addr  = pc_q;
   assign inst_sram_wr    = 1'b0;
   assign inst_sram_size  = INST_SIZE_WORD;
   assign inst_sram_wstrb = INST_WSTRB_NONE;
   assign inst_sram_wdata = 32'd0;

   assign fs_to_ds_valid  = (state_q == FS_HOLD);
   assign fs_pc           = fs_to_ds_valid ? pc_q   : 32'd0;
   assign fs_inst         = fs_to_ds_valid ? inst_q : 32'd0;
   assign fs_adef         = fs_to_ds_valid && adef_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboard bench for if_fetch_ctrl: a simple instruction bus model with
// configurable handshake delays, expected handoffs queued as stimulus is driven.
module tb_if_fetch_ctrl;
   import if_fetch_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        br_taken = 1'b0;
   logic [31:0] br_target = 32'd0;
   logic        ds_allowin = 1'b0;
   logic        inst_sram_req;
   logic        inst_sram_wr;
   logic [1:0]  inst_sram_size;
   logic [3:0]  inst_sram_wstrb;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic        inst_sram_addr_ok = 1'b0;
   logic        inst_sram_data_ok = 1'b0;
   logic [31:0] inst_sram_rdata = 32'd0;
   logic        fs_to_ds_valid;
   logic [31:0] fs_pc;
   logic [31:0] fs_inst;
   logic        fs_adef;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        adef;
   } exp_t;

   exp_t exp_q[$];
   int   compare_count = 0;
   int   mismatch_count = 0;
   int   addr_delay = 0;
   int   data_delay = 0;
   int   accepted = 0;

   if_fetch_ctrl dut (
      .clk               (clk),
      .rst               (rst),
      .br_taken          (br_taken),
      .br_target         (br_target),
      .ds_allowin        (ds_allowin),
      .inst_sram_req     (inst_sram_req),
      .inst_sram_wr      (inst_sram_wr),
      .inst_sram_size    (inst_sram_size),
      .inst_sram_wstrb   (inst_sram_wstrb),
      .inst_sram_addr    (inst_sram_addr),
      .inst_sram_wdata   (inst_sram_wdata),
      .inst_sram_addr_ok (inst_sram_addr_ok),
      .inst_sram_data_ok (inst_sram_data_ok),
      .inst_sram_rdata   (inst_sram_rdata),
      .fs_to_ds_valid    (fs_to_ds_valid),
      .fs_pc             (fs_pc),
      .fs_inst           (fs_inst),
      .fs_adef           (fs_adef)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5a5a_0f0f;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      compare_count++;
      if (actual !== expected) begin
         mismatch_count++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic br, input logic [31:0] tgt, input logic allow);
      br_taken   = br;
      br_target  = tgt;
      ds_allowin = allow;
   endtask

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic push_exp(input logic [31:0] pc, input logic adef);
      exp_t e;
      e.pc   = pc;
      e.adef = adef;
      e.inst = adef ? 32'd0 : mem_word(pc);
      exp_q.push_back(e);
   endtask

   task automatic start_test(input int ad, input int dd);
      rst = 1'b1;
      applyStimulus(1'b0, 32'd0, 1'b0);
      addr_delay = ad;
      data_delay = dd;
      tick();
      tick();
      exp_q.delete();
      accepted = 0;
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
      checkOutput("scoreboard drained", exp_q.size(), 0);
   endtask

   // Bus model: accepts a request after addr_delay waiting cycles, returns data
   // data_delay cycles after the cycle following acceptance; random rdata otherwise.
   initial begin
      int          req_age;
      int          dcnt;
      logic        dq_valid;
      logic [31:0] dq_addr;
      req_age  = 0;
      dcnt     = 0;
      dq_valid = 1'b0;
      dq_addr  = 32'd0;
      forever begin
         @(negedge clk);
         inst_sram_addr_ok = 1'b0;
         inst_sram_data_ok = 1'b0;
         inst_sram_rdata   = $urandom;
         if (rst) begin
            req_age  = 0;
            dq_valid = 1'b0;
         end else begin
            if (dq_valid) begin
               if (dcnt == 0) begin
                  inst_sram_data_ok = 1'b1;
                  inst_sram_rdata   = mem_word(dq_addr);
                  dq_valid          = 1'b0;
               end else begin
                  dcnt--;
               end
            end
            if (inst_sram_req && !dq_valid) begin
               if (req_age >= addr_delay) begin
                  inst_sram_addr_ok = 1'b1;
                  req_age           = 0;
                  dq_valid          = 1'b1;
                  dq_addr           = inst_sram_addr;
                  dcnt              = data_delay;
                  accepted++;
               end else begin
                  req_age++;
               end
            end else begin
               req_age = 0;
            end
         end
      end
   end

   // Handoff monitor: every accepted instruction must match the scoreboard head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (!rst && fs_to_ds_valid && ds_allowin) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected handoff depth", exp_q.size(), 1);
            end else begin
               e = exp_q.pop_front();
               checkOutput("handoff pc", fs_pc, e.pc);
               checkOutput("handoff inst", fs_inst, e.inst);
               checkOutput("handoff adef", fs_adef, e.adef);
            end
         end
      end
   end

   // Time-limit guard so a stuck handshake still ends the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequences; each starts from a fresh reset.
   initial begin
      int cnt;
      int k;

      // Reset values and constant bus outputs.
      start_test(0, 0);
      checkOutput("reset req", inst_sram_req, 0);
      checkOutput("reset valid", fs_to_ds_valid, 0);
      checkOutput("reset fs_pc", fs_pc, 0);
      checkOutput("reset fs_inst", fs_inst, 0);
      checkOutput("reset adef", fs_adef, 0);
      checkOutput("const wr", inst_sram_wr, 0);
      checkOutput("const size", inst_sram_size, 2);
      checkOutput("const wstrb", inst_sram_wstrb, 0);
      checkOutput("const wdata", inst_sram_wdata, 0);

      // Zero-wait bus, decode always ready: sequential PCs and 3-cycle latency.
      for (int i = 0; i < 4; i++) push_exp(32'h1c00_0000 + 32'(4 * i), 1'b0);
      applyStimulus(1'b0, 32'd0, 1'b1);
      rst = 1'b0;
      checkOutput("idle no req", inst_sram_req, 0);
      tick();
      checkOutput("first req", inst_sram_req, 1);
      checkOutput("first addr", inst_sram_addr, 32'h1c00_0000);
      cnt = 1;
      while (!fs_to_ds_valid && cnt < 20) begin
         tick();
         cnt++;
      end
      checkOutput("min latency", cnt, 3);
      drain(60);

      // Delayed addr_ok, then decode stalls for 5 cycles in HOLD.
      start_test(3, 0);
      push_exp(32'h1c00_0000, 1'b0);
      rst = 1'b0;
      tick();
      cnt = 0;
      for (k = 0; k < 12; k++) begin
         checkOutput("req held", inst_sram_req, 1);
         checkOutput("req addr stable", inst_sram_addr, 32'h1c00_0000);
         cnt++;
         if (inst_sram_addr_ok) break;
         tick();
      end
      checkOutput("req cycles", cnt, 4);
      for (k = 0; k < 10 && !fs_to_ds_valid; k++) tick();
      checkOutput("valid after slow addr", fs_to_ds_valid, 1);
      checkOutput("one transaction", accepted, 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("stall valid", fs_to_ds_valid, 1);
         checkOutput("stall pc", fs_pc, 32'h1c00_0000);
         checkOutput("stall inst", fs_inst, mem_word(32'h1c00_0000));
         checkOutput("stall no req", inst_sram_req, 0);
      end
      checkOutput("stall transactions", accepted, 1);
      applyStimulus(1'b0, 32'd0, 1'b1);
      drain(10);
      applyStimulus(1'b0, 32'd0, 1'b0);

      // Two redirects while the request waits for addr_ok: the latest target wins.
      start_test(3, 0);
      push_exp(32'h1c00_0400, 1'b0);
      push_exp(32'h1c00_0404, 1'b0);
      applyStimulus(1'b0, 32'd0, 1'b1);
      rst = 1'b0;
      tick();
      applyStimulus(1'b1, 32'h1c00_0300, 1'b1);
      tick();
      applyStimulus(1'b0, 32'd0, 1'b1);
      checkOutput("redir req kept", inst_sram_req, 1);
      checkOutput("redir addr kept", inst_sram_addr, 32'h1c00_0000);
      applyStimulus(1'b1, 32'h1c00_0400, 1'b1);
      tick();
      applyStimulus(1'b0, 32'd0, 1'b1);
      checkOutput("redir2 addr kept", inst_sram_addr, 32'h1c00_0000);
      drain(60);
      applyStimulus(1'b0, 32'd0, 1'b0);

      // Redirect in WAIT, data arrives two cycles later and must be dropped.
      start_test(0, 2);
      push_exp(32'h1c00_0100, 1'b0);
      push_exp(32'h1c00_0104, 1'b0);
      applyStimulus(1'b0, 32'd0, 1'b1);
      rst = 1'b0;
      for (k = 0; k < 10 && !inst_sram_addr_ok; k++) tick();
      tick();
      applyStimulus(1'b1, 32'h1c00_0100, 1'b1);
      tick();
      applyStimulus(1'b0, 32'd0, 1'b1);
      drain(60);
      applyStimulus(1'b0, 32'd0, 1'b0);

      // Redirect in REQ together with addr_ok.
      start_test(0, 0);
      push_exp(32'h1c00_0500, 1'b0);
      applyStimulus(1'b0, 32'd0, 1'b1);
      rst = 1'b0;
      for (k = 0; k < 10 && !inst_sram_addr_ok; k++) tick();
      applyStimulus(1'b1, 32'h1c00_0500, 1'b1);
      tick();
      applyStimulus(1'b0, 32'd0, 1'b1);
      drain(40);
      applyStimulus(1'b0, 32'd0, 1'b0);

      // Redirect in the same cycle as data_ok: data dropped, refetch at target.
      start_test(0, 0);
      push_exp(32'h1c00_0200, 1'b0);
      applyStimulus(1'b0, 32'd0, 1'b1);
      rst = 1'b0;
      for (k = 0; k < 10 && !inst_sram_data_ok; k++) tick();
      applyStimulus(1'b1, 32'h1c00_0200, 1'b1);
      tick();
      applyStimulus(1'b0, 32'd0, 1'b1);
      for (k = 0; k < 10 && !inst_sram_req; k++) tick();
      checkOutput("refetch addr", inst_sram_addr, 32'h1c00_0200);
      drain(40);
      applyStimulus(1'b0, 32'd0, 1'b0);

      // Redirect from HOLD to a misaligned target raises the fetch address fault.
      start_test(0, 0);
      rst = 1'b0;
      for (k = 0; k < 10 && !fs_to_ds_valid; k++) tick();
      push_exp(32'h1c00_0102, 1'b1);
      applyStimulus(1'b1, 32'h1c00_0102, 1'b0);
      tick();
      applyStimulus(1'b0, 32'd0, 1'b0);
      checkOutput("adef no req", inst_sram_req, 0);
      checkOutput("adef flag", fs_adef, 1);
      checkOutput("adef pc", fs_pc, 32'h1c00_0102);
      checkOutput("adef inst", fs_inst, 0);
      checkOutput("adef valid", fs_to_ds_valid, 1);
      tick();
      checkOutput("adef still no req", inst_sram_req, 0);
      checkOutput("adef transactions", accepted, 1);
      push_exp(32'h1c00_0106, 1'b1);
      applyStimulus(1'b0, 32'd0, 1'b1);
      drain(10);
      applyStimulus(1'b0, 32'd0, 1'b0);

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
      $finish;
   end

endmodule
